window_gen_3x3: RTL and testbench
=================================

# window_gen_3x3

Assembles a 3×3 pixel neighbourhood from a raster pixel stream and the two line-delayed taps produced by the line buffers. It is the reader side of the line-buffer chain in the mean-filter datapath. It tracks raster position and emits one fully populated window per interior pixel, together with frame and line markers, to the downstream averaging stage. No padding is generated: the output image is (IMG_WIDTH-2)×(IMG_HEIGHT-2).

## Interface
Parameters:
- DATA_WIDTH, 8, pixel width in bits
- IMG_WIDTH, 640, pixels per line (≥3)
- IMG_HEIGHT, 480, lines per frame (≥3)

Ports:
- clk  input  1  single clock; all logic rising-edge
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  pixel strobe; no backpressure, every asserted cycle is consumed
- in_sof  input  1  qualifies the current in_valid pixel as frame pixel (0,0)
- data_in  input  DATA_WIDTH  current-line pixel
- row1_in  input  DATA_WIDTH  same column, one line earlier (line-buffer output), aligned with data_in
- row2_in  input  DATA_WIDTH  same column, two lines earlier, aligned with data_in
- out_valid  output  1  window strobe, one-cycle pulse per window
- out_sof  output  1  with out_valid: first window of frame (centre (1,1))
- out_eol  output  1  with out_valid: last window of line (centre x = IMG_WIDTH-2)
- window  output  9*DATA_WIDTH  element (r,c) at bits [(r*3+c)*DATA_WIDTH +: DATA_WIDTH]; r=0 oldest line (row2), c=0 oldest column

## Operation
- Position counters x ∈ [0, IMG_WIDTH-1], y ∈ [0, IMG_HEIGHT-1], width $clog2 of each dimension. Both hold the position of the next pixel to be accepted.
- On in_valid, the current pixel's position is (x,y), or (0,0) if in_sof=1.
  - x advances; it wraps to 0 after IMG_WIDTH-1.
  - On x wrap, y advances; it wraps to 0 after IMG_HEIGHT-1.
  - in_sof=1 forces the next position to (1,0); this is the resync path for mid-frame recovery.
- Column shift register, 3 columns × 3 rows:
  - On in_valid, column 0 ← column 1 ← column 2 ← {row2_in, row1_in, data_in}.
  - Holds when in_valid=0.
  - Not cleared at line start; stale columns are masked by the validity rule.
- Validity: a window is emitted for an accepted pixel at (x,y) iff x≥2 and y≥2. The window centre is (x-1, y-1).
- out_sof = emitted and (x,y)=(2,2). out_eol = emitted and x=IMG_WIDTH-1.
- window contents equal the shift register after the update, i.e. rows {row2,row1,cur} × columns {x-2,x-1,x}.
- window holds its last value while out_valid=0.
- Gaps in in_valid (any length, including mid-line) do not disturb position or contents.

## Timing
- Latency is 1 cycle: a pixel accepted at edge N produces out_valid/window/markers registered at edge N+1. No combinational input→output path.
- out_valid, out_sof and out_eol are deasserted on any cycle following in_valid=0.
- Reset (asynchronous assert): x=0, y=0, shift register = 0, window = 0, out_valid=0, out_sof=0, out_eol=0.
- Reset release is synchronous to clk. The first in_valid after reset is treated as (0,0) regardless of in_sof.
- Reset mid-frame discards all partial state. No window is emitted until two full lines plus three pixels have been accepted.
- in_sof while y≥2: output is suppressed until the new frame reaches (2,2). A window already registered in that cycle still completes.
- Throughput: one window per clock when in_valid is held high.

## Test plan
- Reset values: assert rst_n=0 asynchronously mid-cycle -> all outputs 0 immediately; window=0 after release.
- Ramp frame, IMG_WIDTH=5, IMG_HEIGHT=4, data_in = 10*y+x, row taps modelled correctly -> exactly 3×2=6 windows. First window = {0,1,2,10,11,12,20,21,22} with out_sof=1. out_eol on centres x=3. Last window centre (3,2).
- Random in_valid gaps (30% idle) on the same frame -> identical window sequence; out_valid never on idle+1 cycles.
- Back-to-back frames, no gap, in_sof on each first pixel -> second frame produces out_sof exactly once, at its (2,2) pixel. Total 12 windows.
- in_sof injected at (3,2) of the first frame -> no further windows until the restarted frame's (2,2); counters restart at (1,0) after it.
- rst_n pulsed at (4,3) -> outputs clear. The next frame, without in_sof, yields a first window {0,1,2,10,11,12,20,21,22}.

Source files
------------

// File: rtl/window_gen_3x3.sv
// 3x3 neighbourhood generator: combines the live pixel with two line-delayed taps and emits
// one registered window per interior pixel, tagged with frame/line markers.
module window_gen_3x3 #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic                    in_sof,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic [DATA_WIDTH-1:0]   row1_in,
  input  logic [DATA_WIDTH-1:0]   row2_in,
  output logic                    out_valid,
  output logic                    out_sof,
  output logic                    out_eol,
  output logic [9*DATA_WIDTH-1:0] window
);

  localparam int unsigned XW = $clog2(IMG_WIDTH);
  localparam int unsigned YW = $clog2(IMG_HEIGHT);
  localparam int unsigned CW = 3 * DATA_WIDTH;

  logic [XW-1:0] x_q, x_d, cur_x;
  logic [YW-1:0] y_q, y_d, cur_y;

  // Each column packs rows at [r*DATA_WIDTH], r=0 oldest line (row2), r=2 current line.
  logic [CW-1:0]           col_q [3];
  logic [CW-1:0]           col_n [3];
  logic [9*DATA_WIDTH-1:0] win_d;
  logic [9*DATA_WIDTH-1:0] window_q;
  logic                    emit, sof_d, eol_d;
  logic                    out_valid_q, out_sof_q, out_eol_q;

  always_comb begin
    cur_x = in_sof ? '0 : x_q;
    cur_y = in_sof ? '0 : y_q;
    x_d   = x_q;
    y_d   = y_q;
    if (in_valid) begin
      if (cur_x == XW'(IMG_WIDTH - 1)) begin
        x_d = '0;
        y_d = (cur_y == YW'(IMG_HEIGHT - 1)) ? '0 : cur_y + 1'b1;
      end else begin
        x_d = cur_x + 1'b1;
        y_d = cur_y;
      end
    end
  end

  always_comb begin
    col_n[0] = col_q[1];
    col_n[1] = col_q[2];
    col_n[2] = {data_in, row1_in, row2_in};
    win_d    = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        win_d[(r*3+c)*DATA_WIDTH +: DATA_WIDTH] = col_n[c][r*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    emit  = in_valid && (cur_x >= XW'(2)) && (cur_y >= YW'(2));
    sof_d = emit && (cur_x == XW'(2)) && (cur_y == YW'(2));
    eol_d = emit && (cur_x == XW'(IMG_WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
      for (int c = 0; c < 3; c++) begin
        col_q[c] <= '0;
      end
    end else if (in_valid) begin
      x_q <= x_d;
      y_q <= y_d;
      for (int c = 0; c < 3; c++) begin
        col_q[c] <= col_n[c];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_eol_q   <= 1'b0;
      window_q    <= '0;
    end else begin
      out_valid_q <= emit;
      out_sof_q   <= sof_d;
      out_eol_q   <= eol_d;
      if (emit) begin
        window_q <= win_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_sof   = out_sof_q;
  assign out_eol   = out_eol_q;
  assign window    = window_q;

endmodule

// File: tb/tb_window_gen_3x3.sv
// Bench for window_gen_3x3 on a 5x4 image: a frame-memory model predicts every output cycle,
// and literal expectations pin the model on the ramp frame.
module tb_window_gen_3x3;

  localparam int W  = 5;
  localparam int H  = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_sof = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] row1_in = '0;
  logic [DW-1:0] row2_in = '0;
  logic          out_valid, out_sof, out_eol;
  logic [9*DW-1:0] window;

  window_gen_3x3 #(
    .DATA_WIDTH(DW),
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_sof   (in_sof),
    .data_in  (data_in),
    .row1_in  (row1_in),
    .row2_in  (row2_in),
    .out_valid(out_valid),
    .out_sof  (out_sof),
    .out_eol  (out_eol),
    .window   (window)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: the frame as accepted so far, plus the position of the next pixel.
  logic [DW-1:0] img [H][W];
  int mx = 0;
  int my = 0;

  logic          exp_v = 1'b0, exp_sof = 1'b0, exp_eol = 1'b0;
  logic [9*DW-1:0] exp_win = '0;
  bit            chk_en = 1'b0;

  logic [9*DW-1:0] win_log [$];
  int sof_cnt = 0;
  int eol_cnt = 0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pix(input int f, input int y, input int x);
    return DW'((f * 100 + 10 * y + x) % 256);
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", 72'(out_valid), 72'(exp_v));
      chk("out_sof", 72'(out_sof), 72'(exp_sof));
      chk("out_eol", 72'(out_eol), 72'(exp_eol));
      chk("window", 72'(window), 72'(exp_win));
      if (out_valid) begin
        win_log.push_back(window);
        if (out_sof) sof_cnt++;
        if (out_eol) eol_cnt++;
      end
    end
  end

  task automatic px_in(input int f, input bit sof);
    int cx, cy;
    logic [DW-1:0] d;
    logic ev;
    logic [9*DW-1:0] ew;
    @(negedge clk);
    cx = sof ? 0 : mx;
    cy = sof ? 0 : my;
    d  = pix(f, cy, cx);
    data_in  = d;
    row1_in  = (cy >= 1) ? img[cy-1][cx] : 8'hA5;
    row2_in  = (cy >= 2) ? img[cy-2][cx] : 8'h5A;
    img[cy][cx] = d;
    in_valid = 1'b1;
    in_sof   = sof;
    ev = (cx >= 2) && (cy >= 2);
    ew = '0;
    if (ev) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          ew[(r*3+c)*DW +: DW] = img[cy-2+r][cx-2+c];
    end
    mx = cx + 1;
    my = cy;
    if (mx == W) begin
      mx = 0;
      my = (cy == H - 1) ? 0 : cy + 1;
    end
    @(posedge clk);
    #1;
    exp_v   = ev;
    exp_sof = ev && (cx == 2) && (cy == 2);
    exp_eol = ev && (cx == W - 1);
    if (ev) exp_win = ew;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_sof   = 1'b0;
      @(posedge clk);
      #1;
      exp_v   = 1'b0;
      exp_sof = 1'b0;
      exp_eol = 1'b0;
    end
  endtask

  task automatic frame(input int f, input bit sof, input int npix, input int gap_pct);
    for (int i = 0; i < npix; i++) begin
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) idle($urandom_range(1, 3));
      px_in(f, sof && (i == 0));
    end
  endtask

  // Asserts reset between clock edges and checks the outputs clear without waiting for an edge.
  task automatic async_reset(input string tag);
    @(posedge clk);
    #3;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    exp_v = 1'b0; exp_sof = 1'b0; exp_eol = 1'b0; exp_win = '0;
    mx = 0; my = 0;
    #1;
    chk({tag, "_valid"}, 72'(out_valid), 72'd0);
    chk({tag, "_sof"}, 72'(out_sof), 72'd0);
    chk({tag, "_eol"}, 72'(out_eol), 72'd0);
    chk({tag, "_window"}, 72'(window), 72'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
  endtask

  localparam logic [71:0] RampFirst =
    {8'd22, 8'd21, 8'd20, 8'd12, 8'd11, 8'd10, 8'd2, 8'd1, 8'd0};

  initial begin
    int base, sbase, ebase;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        img[y][x] = '0;

    #2 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Ramp frame, no gaps
    base = win_log.size(); sbase = sof_cnt; ebase = eol_cnt;
    frame(0, 1'b1, W * H, 0);
    idle(2);
    chk("ramp_count", 72'(win_log.size() - base), 72'd6);
    chk("ramp_first", win_log[base], RampFirst);
    chk("ramp_sof_cnt", 72'(sof_cnt - sbase), 72'd1);
    chk("ramp_eol_cnt", 72'(eol_cnt - ebase), 72'd2);
    chk("ramp_last_centre", 72'(win_log[win_log.size()-1][4*DW +: DW]), 72'd23);

    // Same frame content with idle gaps
    base = win_log.size();
    frame(0, 1'b1, W * H, 30);
    idle(2);
    chk("gap_count", 72'(win_log.size() - base), 72'd6);
    chk("gap_first", win_log[base], RampFirst);

    // Back-to-back frames
    base = win_log.size(); sbase = sof_cnt;
    frame(3, 1'b1, W * H, 0);
    frame(4, 1'b1, W * H, 0);
    idle(2);
    chk("b2b_count", 72'(win_log.size() - base), 72'd12);
    chk("b2b_sof_cnt", 72'(sof_cnt - sbase), 72'd2);

    // Resync: in_sof arrives on the pixel at (3,2)
    base = win_log.size();
    frame(5, 1'b1, 2 * W + 3, 0);
    frame(6, 1'b1, W * H, 0);
    idle(2);
    chk("resync_count", 72'(win_log.size() - base), 72'd7);
    chk("resync_centre", 72'(win_log[base+1][4*DW +: DW]), 72'(pix(6, 1, 1)));

    // Reset after pixel (3,3); the next pixel (4,3) is never accepted
    frame(7, 1'b1, 3 * W + 4, 0);
    async_reset("midrst");
    base = win_log.size();
    frame(0, 1'b0, W * H, 0);
    idle(2);
    chk("post_rst_count", 72'(win_log.size() - base), 72'd6);
    chk("post_rst_first", win_log[base], RampFirst);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
